imem_injector: RTL and testbench
================================

Name: imem_injector

Overview:
- Responder end of the core instruction-fetch bus: drives `imem_data_o` back to the core in answer to `imem_addr_i`.
- Serves instructions that a host (bench, debug port, boot loader) pushes through a valid/ready queue; substitutes NOP when the queue is empty.
- Monitors the fetch address stream, flags control-flow redirects (address != previous+4) and records the target, so jump/branch behaviour is checked in hardware without a program binary.

Parameters:
- DEPTH, 8, instruction queue entries (power of two, >=2)
- NOP_INSTR, 32'h00000013, filler instruction (addi x0,x0,0)
- CNT_W, 16, width of delivered-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- inj_valid_i  in  1  host offers instruction
- inj_data_i  in  32  instruction word
- inj_ready_o  out  1  queue accepts word this cycle
- flush_i  in  1  discard queue and current word
- imem_addr_i  in  32  fetch address from core
- imem_data_o  out  32  instruction word to core
- redirect_o  out  1  one-cycle pulse: non-sequential fetch seen
- redirect_pc_o  out  32  address of most recent non-sequential fetch
- fetch_count_o  out  CNT_W  queued instructions delivered, saturating
- level_o  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Reset (rst high at an edge) clears:
  - queue pointers, `level_o` = 0
  - `last_addr_q` = 0, `first_q` = 1, `cur_q` = NOP_INSTR
  - `redirect_o` = 0, `redirect_pc_o` = 0, `fetch_count_o` = 0
- While rst is high: `inj_ready_o` = 0 and `imem_data_o` = NOP_INSTR.
- Push: `inj_ready_o` = !full & !flush_i & !rst. A word is written when `inj_valid_i` & `inj_ready_o`. Ready does not depend on a same-cycle pop, so a full queue stays unready for that cycle even if it pops.
- Fetch strobe (combinational): `fetch_stb` = `first_q` | (`imem_addr_i` != `last_addr_q`). A held address (stall) is not a new fetch.
- Data out (combinational):
  - `fetch_stb` & !empty -> queue head
  - `fetch_stb` & empty -> NOP_INSTR
  - otherwise -> `cur_q`
- At each edge where `fetch_stb` is high:
  - `cur_q` <= `imem_data_o`
  - `last_addr_q` <= `imem_addr_i`
  - `first_q` <= 0
  - if !empty: pop head and increment `fetch_count_o`, saturating at all-ones
- Push into an empty queue is not visible on the same cycle. A same-cycle fetch receives NOP; the word is served at the next fetch. Push and pop in the same cycle leave `level_o` unchanged.
- Redirect detection: at an edge where `fetch_stb` & !`first_q` & (`imem_addr_i` != `last_addr_q`+4), with 32-bit wrap on the +4:
  - `redirect_o` <= 1 for exactly one cycle
  - `redirect_pc_o` <= `imem_addr_i`
  - `redirect_o` is otherwise 0; `redirect_pc_o` holds its value.
- Flush (`flush_i` high at an edge):
  - queue emptied, `cur_q` <= NOP_INSTR, `first_q` <= 1
  - any same-cycle push is refused (ready is low); a same-cycle pop is void
  - `fetch_count_o` and `redirect_pc_o` are kept
- Reset mid-operation: all state is lost; the first fetch after reset is never flagged as a redirect.
- Full/empty: pointers carry one extra wrap bit. Full when occupancy == DEPTH; empty when 0.

Test Plan:
- Reset, then core fetches 0x0,0x4,0x8 with empty queue -> `imem_data_o` = 0x00000013 each fetch; `redirect_o` never asserts; `fetch_count_o` = 0.
- Push 0x00a00213 then 0x00150593, addresses 0x0,0x4, address held at 0x4 for 3 cycles -> data 0x00a00213 then 0x00150593 held stable while stalled; `fetch_count_o` = 2; `level_o` = 0.
- Push 0x020000ef at PC 0x10, core then fetches 0x14 and 0x30 -> `redirect_o` pulses exactly one cycle after the 0x30 fetch; `redirect_pc_o` = 0x00000030.
- Push DEPTH words with no fetches -> `inj_ready_o` = 0 and `level_o` = 8. One fetch -> ready returns the next cycle; FIFO order preserved on readout.
- Queue holds 3 words; assert `flush_i` together with `inj_valid_i` -> `level_o` = 0, the pushed word is dropped, the next fetch returns NOP, and a non-sequential address on that fetch does not pulse `redirect_o`.
- Address 0xFFFFFFFC followed by 0x00000000 -> no redirect (wrap treated as sequential).

Source files
------------

// File: rtl/imem_injector.sv
// Instruction-fetch responder: serves host-queued words on each new fetch, NOP when
// empty, and flags non-sequential fetch addresses (redirects) for hardware checking.

// Generic single-clock queue with wrap-bit pointers and a head peek port.
// Latency: a written word is visible at rd_dat one cycle after the write edge.
// Backpressure: writes are dropped while full; flush empties the queue at the edge.
module imem_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic                     rd_vld,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign level  = wr_ptr - rd_ptr;
  assign full   = (level == (AW+1)'(DEPTH));
  assign rd_vld = (level != '0);
  assign rd_dat = mem[rd_ptr[AW-1:0]];
  assign wr_en  = wr_vld & ~full;
  assign rd_en  = rd_rdy & rd_vld;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en && !flush && !rst) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// Fetch responder top: queue head on a new fetch address, NOP if empty, held word on stall.
// Latency: data is combinational from imem_addr_i; redirect flag/PC register one cycle later.
// Backpressure: inj_ready_o low while full, flushing or in reset; ready ignores same-cycle pops.
module imem_injector #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inj_valid_i,
  input  logic [31:0]              inj_data_i,
  output logic                     inj_ready_o,
  input  logic                     flush_i,
  input  logic [31:0]              imem_addr_i,
  output logic [31:0]              imem_data_o,
  output logic                     redirect_o,
  output logic [31:0]              redirect_pc_o,
  output logic [CNT_W-1:0]         fetch_count_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  logic [31:0] last_addr_q;
  logic        first_q;
  logic [31:0] cur_q;

  logic        q_full;
  logic        head_vld;
  logic [31:0] head_dat;
  logic        push_vld;
  logic        pop_vld;
  logic        fetch_stb;
  logic        redirect_d;

  assign inj_ready_o = ~q_full & ~flush_i & ~rst;
  assign push_vld    = inj_valid_i & inj_ready_o;

  // A held address is a stall, not a new fetch; the first fetch after reset/flush always counts.
  assign fetch_stb   = first_q | (imem_addr_i != last_addr_q);
  assign pop_vld     = fetch_stb & head_vld & ~flush_i;
  assign redirect_d  = fetch_stb & ~first_q & (imem_addr_i != (last_addr_q + 32'd4));

  always_comb begin
    imem_data_o = cur_q;
    if (rst) begin
      imem_data_o = NOP_INSTR;
    end else if (fetch_stb) begin
      imem_data_o = head_vld ? head_dat : NOP_INSTR;
    end
  end

  imem_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush_i),
    .wr_vld (push_vld),
    .wr_dat (inj_data_i),
    .rd_rdy (pop_vld),
    .rd_vld (head_vld),
    .rd_dat (head_dat),
    .full   (q_full),
    .level  (level_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr_q <= '0;
      first_q     <= 1'b1;
      cur_q       <= NOP_INSTR;
    end else if (flush_i) begin
      last_addr_q <= fetch_stb ? imem_addr_i : last_addr_q;
      first_q     <= 1'b1;
      cur_q       <= NOP_INSTR;
    end else if (fetch_stb) begin
      last_addr_q <= imem_addr_i;
      first_q     <= 1'b0;
      cur_q       <= imem_data_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      redirect_o <= redirect_d;
      if (redirect_d) redirect_pc_o <= imem_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_o <= '0;
    end else if (pop_vld && (fetch_count_o != {CNT_W{1'b1}})) begin
      fetch_count_o <= fetch_count_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_injector.sv
// Bench for imem_injector: directed vector table, hand sequences for full/flush,
// then random traffic checked against a queue-based reference model.
module tb_imem_injector;

  localparam int          DEPTH = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inj_valid_i = 1'b0;
  logic [31:0] inj_data_i = '0;
  logic        inj_ready_o;
  logic        flush_i = 1'b0;
  logic [31:0] imem_addr_i = '0;
  logic [31:0] imem_data_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic [15:0] fetch_count_o;
  logic [3:0]  level_o;

  imem_injector #(.DEPTH(DEPTH), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .inj_valid_i   (inj_valid_i),
    .inj_data_i    (inj_data_i),
    .inj_ready_o   (inj_ready_o),
    .flush_i       (flush_i),
    .imem_addr_i   (imem_addr_i),
    .imem_data_o   (imem_data_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .fetch_count_o (fetch_count_o),
    .level_o       (level_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain queue plus the few remembered facts about the fetch stream.
  logic [31:0] mq[$];
  logic [31:0] m_last = '0;
  logic [31:0] m_cur  = NOP;
  logic [31:0] m_rpc  = '0;
  logic        m_first = 1'b1;
  logic        m_rdr = 1'b0;
  int          m_cnt = 0;

  logic [31:0] pre_data;
  logic        pre_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [31:0] d,
                      input logic f, input logic [31:0] a);
    logic        stb, e_rdy, push, pop, rdr;
    logic [31:0] e_data;
    @(negedge clk);
    rst = r; inj_valid_i = v; inj_data_i = d; flush_i = f; imem_addr_i = a;
    #1;
    e_rdy  = (mq.size() < DEPTH) && !f && !r;
    stb    = m_first || (a != m_last);
    e_data = r ? NOP : (stb ? ((mq.size() > 0) ? mq[0] : NOP) : m_cur);
    pre_data = imem_data_o;
    pre_rdy  = inj_ready_o;
    chk("model_data",  imem_data_o, e_data);
    chk("model_ready", {31'b0, inj_ready_o}, {31'b0, e_rdy});
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_last = '0; m_first = 1'b1; m_cur = NOP; m_rdr = 1'b0; m_rpc = '0; m_cnt = 0;
    end else begin
      push  = v && e_rdy;
      pop   = stb && (mq.size() > 0) && !f;
      rdr   = stb && !m_first && (a != m_last + 32'd4);
      m_rdr = rdr;
      if (rdr) m_rpc = a;
      if (stb) begin
        m_cur = e_data; m_last = a; m_first = 1'b0;
      end
      if (pop) begin
        void'(mq.pop_front());
        if (m_cnt < 65535) m_cnt++;
      end
      if (push) mq.push_back(d);
      if (f) begin
        mq.delete(); m_cur = NOP; m_first = 1'b1;
      end
    end
    #1;
    chk("model_redirect", {31'b0, redirect_o}, {31'b0, m_rdr});
    chk("model_rpc",      redirect_pc_o, m_rpc);
    chk("model_count",    {16'b0, fetch_count_o}, 32'(m_cnt));
    chk("model_level",    {28'b0, level_o}, 32'(mq.size()));
  endtask

  typedef struct {
    logic        r, v;
    logic [31:0] d;
    logic        f;
    logic [31:0] a;
    logic [31:0] e_data;
    logic        e_rdy, e_rdr;
    logic [3:0]  e_lvl;
    logic [15:0] e_cnt;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // r v d f a | data rdy rdr lvl cnt rpc (registered fields observed after the edge)
    tbl[0]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  NOP, 1'b0, 1'b0, 4'd0, 16'd0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  NOP, 1'b1, 1'b0, 4'd0, 16'd0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h4,  NOP, 1'b1, 1'b0, 4'd0, 16'd0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h8,  NOP, 1'b1, 1'b0, 4'd0, 16'd0, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0,  NOP, 1'b0, 1'b0, 4'd0, 16'd0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'h00a00213, 1'b0, 32'h0, NOP, 1'b1, 1'b0, 4'd1, 16'd0, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 32'h00150593, 1'b0, 32'h0, NOP, 1'b1, 1'b0, 4'd2, 16'd0, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h4,  32'h00a00213, 1'b1, 1'b0, 4'd1, 16'd1, 32'h0};
    tbl[8]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h8,  32'h00150593, 1'b1, 1'b0, 4'd0, 16'd2, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h8,  32'h00150593, 1'b1, 1'b0, 4'd0, 16'd2, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h8,  32'h00150593, 1'b1, 1'b0, 4'd0, 16'd2, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h8,  32'h00150593, 1'b1, 1'b0, 4'd0, 16'd2, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 32'h020000ef, 1'b0, 32'h10, NOP, 1'b1, 1'b1, 4'd1, 16'd2, 32'h10};
    tbl[13] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h14, 32'h020000ef, 1'b1, 1'b0, 4'd0, 16'd3, 32'h10};
    tbl[14] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h30, NOP, 1'b1, 1'b1, 4'd0, 16'd3, 32'h30};
    tbl[15] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h30, NOP, 1'b1, 1'b0, 4'd0, 16'd3, 32'h30};
    tbl[16] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'hFFFFFFFC, NOP, 1'b1, 1'b1, 4'd0, 16'd3, 32'hFFFFFFFC};
    tbl[17] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  NOP, 1'b1, 1'b0, 4'd0, 16'd3, 32'hFFFFFFFC};

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].a);
      chk($sformatf("tbl%0d_data", i),  pre_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_ready", i), {31'b0, pre_rdy}, {31'b0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_redirect", i), {31'b0, redirect_o}, {31'b0, tbl[i].e_rdr});
      chk($sformatf("tbl%0d_level", i), {28'b0, level_o}, {28'b0, tbl[i].e_lvl});
      chk($sformatf("tbl%0d_count", i), {16'b0, fetch_count_o}, {16'b0, tbl[i].e_cnt});
      chk($sformatf("tbl%0d_rpc", i),   redirect_pc_o, tbl[i].e_rpc);
    end

    // Fill to DEPTH with no new fetch, then drain and confirm order.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'h1000 + 32'(i), 1'b0, 32'h100);
    chk("full_level", {28'b0, level_o}, 32'd8);
    step(1'b0, 1'b1, 32'hdead, 1'b0, 32'h100);
    chk("full_ready", {31'b0, pre_rdy}, 32'd0);
    step(1'b0, 1'b1, 32'hbeef, 1'b0, 32'h104);
    chk("full_pop_ready", {31'b0, pre_rdy}, 32'd0);
    chk("full_pop_data", pre_data, 32'h1000);
    chk("full_pop_level", {28'b0, level_o}, 32'd7);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h104);
    chk("ready_returns", {31'b0, pre_rdy}, 32'd1);
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h104 + 32'(4 * i));
      chk($sformatf("order%0d", i), pre_data, 32'h1000 + 32'(i));
    end
    chk("drained_level", {28'b0, level_o}, 32'd0);

    // Flush with a concurrent push, then a non-sequential first fetch.
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h2000 + 32'(i), 1'b0, 32'h200);
    chk("preflush_level", {28'b0, level_o}, 32'd3);
    step(1'b0, 1'b1, 32'h9999, 1'b1, 32'h200);
    chk("flush_ready", {31'b0, pre_rdy}, 32'd0);
    chk("flush_level", {28'b0, level_o}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h500);
    chk("postflush_data", pre_data, NOP);
    chk("postflush_redirect", {31'b0, redirect_o}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h504);
    chk("dropped_push", pre_data, NOP);

    // Random traffic against the reference model.
    begin
      logic [31:0] addr;
      addr = 32'h0;
      for (int n = 0; n < 3000; n++) begin
        int sel;
        logic r, v, f;
        sel = $urandom_range(0, 99);
        if (sel < 30)      addr = addr;
        else if (sel < 80) addr = addr + 32'd4;
        else if (sel < 83) addr = 32'hFFFFFFFC;
        else               addr = {$urandom_range(0, 255), 2'b00};
        r = ($urandom_range(0, 199) == 0);
        f = ($urandom_range(0, 49) == 0);
        v = ($urandom_range(0, 1) == 1);
        step(r, v, $urandom, f, addr);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
